// File: rtl/regbus_axi_pkg.sv
// Shared payload types for the regbus_to_axi bridge.
// Provides the regbus request/response structs and the AXI4+ATOP channel,
// request and response structs at the bridge's default widths, plus the
// AXI response, burst and atomic-operation encodings.
package regbus_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [5:0] ATOP_NONE   = 6'b000000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              valid;
    } reg_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

// File: rtl/regbus_to_axi.sv
// Single-outstanding regbus -> AXI4+ATOP master bridge.
// Each regbus request becomes one single-beat AXI read or write; completion
// (read data, error flag) is returned as a one-cycle regbus ready.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   reg_req_i  regbus request {addr, write, wdata, wstrb, valid}
//   reg_rsp_o  regbus response {rdata, error, ready}
//   axi_req_o  AXI master request channels (AW, W, AR, b_ready, r_ready)
//   axi_rsp_i  AXI responses (aw/w/ar_ready, B, R)
module regbus_to_axi #(
    parameter int unsigned AxiAddrWidth = regbus_axi_pkg::ADDR_W,
    parameter int unsigned AxiDataWidth = regbus_axi_pkg::DATA_W,
    parameter int unsigned AxiIdWidth   = regbus_axi_pkg::ID_W,
    parameter int unsigned AxiUserWidth = regbus_axi_pkg::USER_W,
    parameter type reg_req_t = regbus_axi_pkg::reg_req_t,
    parameter type reg_rsp_t = regbus_axi_pkg::reg_rsp_t,
    parameter type axi_req_t = regbus_axi_pkg::axi_req_t,
    parameter type axi_rsp_t = regbus_axi_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output axi_req_t axi_req_o,
    input  axi_rsp_t axi_rsp_i
);

    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam logic [2:0]  AxiSize   = 3'($clog2(StrbWidth));

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WR_RESP,
        READ,
        RD_DATA,
        DONE
    } state_e;

    state_e                  state_q;
    logic                    aw_valid_q;
    logic                    w_valid_q;
    logic                    ar_valid_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [AxiDataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0]    wstrb_q;
    logic [AxiDataWidth-1:0] rdata_q;
    logic                    error_q;
    logic                    ready_q;

    // A pending channel is done once its valid is low or it handshakes now.
    logic aw_done_c;
    logic w_done_c;
    assign aw_done_c = !aw_valid_q || axi_rsp_i.aw_ready;
    assign w_done_c  = !w_valid_q  || axi_rsp_i.w_ready;

    // Transaction sequencer; valids, payload and response are all registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        addr_q  <= AxiAddrWidth'(reg_req_i.addr);
                        wdata_q <= AxiDataWidth'(reg_req_i.wdata);
                        wstrb_q <= StrbWidth'(reg_req_i.wstrb);
                        if (reg_req_i.write) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= WRITE;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                WRITE: begin
                    // AW and W retire independently, in any order.
                    if (axi_rsp_i.aw_ready) aw_valid_q <= 1'b0;
                    if (axi_rsp_i.w_ready)  w_valid_q  <= 1'b0;
                    if (aw_done_c && w_done_c) state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (axi_rsp_i.b_valid) begin
                        rdata_q <= '0;
                        error_q <= (axi_rsp_i.b.resp == regbus_axi_pkg::RESP_SLVERR) ||
                                   (axi_rsp_i.b.resp == regbus_axi_pkg::RESP_DECERR);
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                READ: begin
                    if (axi_rsp_i.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rsp_i.r_valid) begin
                        rdata_q <= AxiDataWidth'(axi_rsp_i.r.data);
                        // A single-beat read must also arrive with last set.
                        error_q <= (axi_rsp_i.r.resp == regbus_axi_pkg::RESP_SLVERR) ||
                                   (axi_rsp_i.r.resp == regbus_axi_pkg::RESP_DECERR) ||
                                   !axi_rsp_i.r.last;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Request is not sampled here, so a held valid is not re-accepted.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Map registered state onto the AXI channels; fixed fields are constants.
    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = AxiIdWidth'(0);
        axi_req_o.aw.addr   = addr_q;
        axi_req_o.aw.len    = 8'd0;
        axi_req_o.aw.size   = AxiSize;
        axi_req_o.aw.burst  = regbus_axi_pkg::BURST_INCR;
        axi_req_o.aw.lock   = 1'b0;
        axi_req_o.aw.cache  = 4'd0;
        axi_req_o.aw.prot   = 3'd0;
        axi_req_o.aw.qos    = 4'd0;
        axi_req_o.aw.region = 4'd0;
        axi_req_o.aw.atop   = regbus_axi_pkg::ATOP_NONE;
        axi_req_o.aw.user   = AxiUserWidth'(0);
        axi_req_o.aw_valid  = aw_valid_q;
        axi_req_o.w.data    = wdata_q;
        axi_req_o.w.strb    = wstrb_q;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w.user    = AxiUserWidth'(0);
        axi_req_o.w_valid   = w_valid_q;
        axi_req_o.b_ready   = (state_q == WR_RESP);
        axi_req_o.ar.id     = AxiIdWidth'(0);
        axi_req_o.ar.addr   = addr_q;
        axi_req_o.ar.len    = 8'd0;
        axi_req_o.ar.size   = AxiSize;
        axi_req_o.ar.burst  = regbus_axi_pkg::BURST_INCR;
        axi_req_o.ar.lock   = 1'b0;
        axi_req_o.ar.cache  = 4'd0;
        axi_req_o.ar.prot   = 3'd0;
        axi_req_o.ar.qos    = 4'd0;
        axi_req_o.ar.region = 4'd0;
        axi_req_o.ar.user   = AxiUserWidth'(0);
        axi_req_o.ar_valid  = ar_valid_q;
        axi_req_o.r_ready   = (state_q == RD_DATA);
    end

    // Regbus response straight from the completion registers.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = ready_q;
    end

    // IDs and user fields of responses carry no meaning for a single-outstanding master.
    logic unused_rsp;
    assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

endmodule

// File: tb/tb_regbus_to_axi.sv
// Self-checking bench for regbus_to_axi: a table of directed transactions
// against a configurable single-outstanding AXI responder, plus hand-written
// sequences for back-to-back traffic, held-valid in DONE and mid-write reset.
module tb_regbus_to_axi;
    import regbus_axi_pkg::*;

    logic     clk;
    logic     rst;
    reg_req_t reg_req;
    reg_rsp_t reg_rsp;
    axi_req_t axi_req;
    axi_rsp_t axi_rsp;

    int n_cmp  = 0;
    int n_fail = 0;
    int aw_hs  = 0;
    int w_hs   = 0;
    int ar_hs  = 0;

    // Responder configuration and expected request payload.
    int          cfg_aw_dly, cfg_w_dly, cfg_ar_dly, cfg_b_dly, cfg_r_dly;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    logic        cfg_rlast;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          rlast;
        bit          perturb;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    regbus_to_axi dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp),
        .axi_req_o (axi_req),
        .axi_rsp_i (axi_rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI responder: drives readies/responses at the falling edge for the next rising edge.
    initial begin : responder
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_seen, w_seen, ar_seen;
        bit aw_fire, w_fire, ar_fire, b_fire, r_fire;
        bit aw_wait, w_wait, ar_wait;
        logic [31:0] aw_hold, w_hold, ar_hold;
        axi_rsp = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        aw_hold = '0; w_hold = '0; ar_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi_rsp = '0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (aw_fire) check("aw_valid_drop", 64'(axi_req.aw_valid), 64'(0));
                if (w_fire)  check("w_valid_drop",  64'(axi_req.w_valid),  64'(0));
                if (ar_fire) check("ar_valid_drop", 64'(axi_req.ar_valid), 64'(0));
                if (aw_wait) check("aw_stable", 64'({axi_req.aw_valid, axi_req.aw.addr}), 64'({1'b1, aw_hold}));
                if (w_wait)  check("w_stable",  64'({axi_req.w_valid, axi_req.w.data}),   64'({1'b1, w_hold}));
                if (ar_wait) check("ar_stable", 64'({axi_req.ar_valid, axi_req.ar.addr}), 64'({1'b1, ar_hold}));

                if (b_fire) begin
                    axi_rsp.b_valid = 1'b0;
                    aw_seen = 0; w_seen = 0; b_cnt = 0;
                end
                if (r_fire) begin
                    axi_rsp.r_valid = 1'b0;
                    ar_seen = 0; r_cnt = 0;
                end
                if (aw_seen && w_seen && !axi_rsp.b_valid) begin
                    if (b_cnt >= cfg_b_dly) begin
                        axi_rsp.b_valid = 1'b1;
                        axi_rsp.b.resp  = cfg_resp;
                    end else b_cnt++;
                end
                if (ar_seen && !axi_rsp.r_valid) begin
                    if (r_cnt >= cfg_r_dly) begin
                        axi_rsp.r_valid = 1'b1;
                        axi_rsp.r.data  = cfg_rdata;
                        axi_rsp.r.resp  = cfg_resp;
                        axi_rsp.r.last  = cfg_rlast;
                    end else r_cnt++;
                end

                if (axi_req.aw_valid) begin axi_rsp.aw_ready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
                else begin axi_rsp.aw_ready = 1'b0; aw_cnt = 0; end
                if (axi_req.w_valid) begin axi_rsp.w_ready = (w_cnt >= cfg_w_dly); w_cnt++; end
                else begin axi_rsp.w_ready = 1'b0; w_cnt = 0; end
                if (axi_req.ar_valid) begin axi_rsp.ar_ready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
                else begin axi_rsp.ar_ready = 1'b0; ar_cnt = 0; end

                aw_fire = axi_req.aw_valid && axi_rsp.aw_ready;
                aw_wait = axi_req.aw_valid && !axi_rsp.aw_ready;
                aw_hold = axi_req.aw.addr;
                w_fire  = axi_req.w_valid && axi_rsp.w_ready;
                w_wait  = axi_req.w_valid && !axi_rsp.w_ready;
                w_hold  = axi_req.w.data;
                ar_fire = axi_req.ar_valid && axi_rsp.ar_ready;
                ar_wait = axi_req.ar_valid && !axi_rsp.ar_ready;
                ar_hold = axi_req.ar.addr;

                if (aw_fire) begin
                    aw_seen = 1; aw_hs++;
                    check("aw_addr", 64'(axi_req.aw.addr), 64'(exp_addr));
                    check("aw_ctrl",
                          64'({axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.lock,
                               axi_req.aw.cache, axi_req.aw.prot, axi_req.aw.qos, axi_req.aw.region,
                               axi_req.aw.atop, axi_req.aw.id, axi_req.aw.user}),
                          64'({8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 4'd0, 1'b0}));
                end
                if (w_fire) begin
                    w_seen = 1; w_hs++;
                    check("w_data", 64'(axi_req.w.data), 64'(exp_wdata));
                    check("w_strb_last", 64'({axi_req.w.strb, axi_req.w.last, axi_req.w.user}),
                          64'({exp_wstrb, 1'b1, 1'b0}));
                end
                if (ar_fire) begin
                    ar_seen = 1; ar_hs++;
                    check("ar_addr", 64'(axi_req.ar.addr), 64'(exp_addr));
                    check("ar_ctrl",
                          64'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.lock,
                               axi_req.ar.cache, axi_req.ar.prot, axi_req.ar.qos, axi_req.ar.region,
                               axi_req.ar.id, axi_req.ar.user}),
                          64'({8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0}));
                end
                b_fire = axi_rsp.b_valid && axi_req.b_ready;
                r_fire = axi_rsp.r_valid && axi_req.r_ready;
            end
        end
    end

    // Present one request at the current falling edge and wait for ready.
    task automatic do_txn(input vec_t v, input bit hold_done, output int lat,
                          output logic [31:0] rd, output logic er);
        exp_addr      = v.addr;
        exp_wdata     = v.wdata;
        exp_wstrb     = v.wstrb;
        reg_req.valid = 1'b1;
        reg_req.write = v.wr;
        reg_req.addr  = v.addr;
        reg_req.wdata = v.wdata;
        reg_req.wstrb = v.wstrb;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (v.perturb && lat == 4) begin
                reg_req.write = ~v.wr;
                reg_req.addr  = 32'h0000_3000;
                reg_req.wdata = 32'hFFFF_FFFF;
            end
        end while (!reg_rsp.ready && lat < 200);
        if (lat >= 200) check("txn_timeout", 64'(lat), 64'(v.exp_lat));
        rd = reg_rsp.rdata;
        er = reg_rsp.error;
        if (hold_done) @(negedge clk);
        reg_req.valid = 1'b0;
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_aw_dly = v.aw_dly;
        cfg_w_dly  = v.w_dly;
        cfg_ar_dly = v.ar_dly;
        cfg_b_dly  = v.rsp_dly;
        cfg_r_dly  = v.rsp_dly;
        cfg_resp   = v.resp;
        cfg_rdata  = v.rdata;
        cfg_rlast  = v.rlast;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          aw0, w0, ar0;
        set_cfg(v);
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(reg_rsp.ready), 64'(0));
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
        do_txn(v, 1'b0, lat, rd, er);
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
        check({tag, "_error"}, 64'(er), 64'(v.exp_err));
        check({tag, "_beats"}, 64'({8'(aw_hs - aw0), 8'(w_hs - w0), 8'(ar_hs - ar0)}),
              64'({8'(v.wr ? 1 : 0), 8'(v.wr ? 1 : 0), 8'(v.wr ? 0 : 1)}));
    endtask

    initial begin : main
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          aw0, w0, ar0;
        vec_t        v;

        // wr addr wdata wstrb awd wd ard rspd resp rdata rlast pert exp_rdata err lat
        vecs[0]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, RESP_OKAY,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3};
        vecs[1]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 0, 0, 0, 0, RESP_OKAY,   32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{1'b1, 32'h1004, 32'h11112222, 4'hF, 5, 0, 0, 0, RESP_OKAY,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 8};
        vecs[3]  = '{1'b1, 32'h1008, 32'h33334444, 4'h3, 0, 5, 0, 0, RESP_OKAY,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 8};
        vecs[4]  = '{1'b1, 32'h100C, 32'h55556666, 4'hF, 0, 0, 0, 0, RESP_SLVERR, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 3};
        vecs[5]  = '{1'b0, 32'h2000, 32'h0,        4'h0, 0, 0, 0, 0, RESP_DECERR, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1, 3};
        vecs[6]  = '{1'b0, 32'h2004, 32'h0,        4'h0, 0, 0, 0, 0, RESP_OKAY,   32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 3};
        vecs[7]  = '{1'b1, 32'h1010, 32'h77778888, 4'hF, 0, 0, 0, 0, RESP_EXOKAY, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3};
        vecs[8]  = '{1'b1, 32'h1014, 32'h9999AAAA, 4'h0, 0, 0, 0, 0, RESP_OKAY,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3};
        vecs[9]  = '{1'b0, 32'h1003, 32'h0,        4'h0, 0, 0, 2, 3, RESP_OKAY,   32'hA5A5A5A5, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 8};
        vecs[10] = '{1'b0, 32'h2008, 32'h0,        4'h0, 0, 0, 0, 0, RESP_EXOKAY, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 3};
        vecs[11] = '{1'b1, 32'h1018, 32'hBBBBCCCC, 4'hC, 0, 0, 0, 4, RESP_OKAY,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 7};
        vecs[12] = '{1'b0, 32'h2000, 32'h0,        4'h0, 0, 0, 0, 10, RESP_OKAY,  32'h0BADF00D, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 13};

        reg_req = '0;
        rst     = 1'b1;
        set_cfg(vecs[0]);
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                 axi_req.b_ready, axi_req.r_ready, reg_rsp.ready, reg_rsp.error}), 64'(0));
        check("reset_rdata", 64'(reg_rsp.rdata), 64'(0));
        #1 rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Eight back-to-back writes, each presented on the previous ready.
        v = vecs[0];
        set_cfg(v);
        @(negedge clk);
        aw0 = aw_hs; w0 = w_hs;
        for (int i = 0; i < 8; i++) begin
            v.addr  = 32'h4000 + 32'(4 * i);
            v.wdata = 32'hB2B0_0000 + 32'(i);
            do_txn(v, 1'b0, lat, rd, er);
            check($sformatf("b2b%0d_latency", i), 64'(lat), 64'(i == 0 ? 3 : 4));
            check($sformatf("b2b%0d_error", i), 64'(er), 64'(0));
        end
        check("b2b_aw_count", 64'(aw_hs - aw0), 64'(8));
        check("b2b_w_count", 64'(w_hs - w0), 64'(8));

        // Valid held through DONE must not start a second transaction.
        @(negedge clk);
        aw0 = aw_hs; ar0 = ar_hs;
        v.addr = 32'h4100; v.wdata = 32'h0000_1234;
        do_txn(v, 1'b1, lat, rd, er);
        check("hold_latency", 64'(lat), 64'(3));
        repeat (6) @(negedge clk);
        check("hold_no_reaccept", 64'({8'(aw_hs - aw0), 8'(ar_hs - ar0), 7'd0, reg_rsp.ready}),
              64'({8'd1, 8'd0, 7'd0, 1'b0}));

        // Reset while waiting for B.
        cfg_b_dly = 20;
        @(negedge clk);
        exp_addr = 32'h5000; exp_wdata = 32'h5555_0000; exp_wstrb = 4'hF;
        reg_req.valid = 1'b1; reg_req.write = 1'b1; reg_req.addr = 32'h5000;
        reg_req.wdata = 32'h5555_0000; reg_req.wstrb = 4'hF;
        repeat (2) @(negedge clk);
        check("in_wr_resp", 64'({axi_req.b_ready, axi_req.aw_valid, axi_req.w_valid}), 64'({1'b1, 1'b0, 1'b0}));
        reg_req.valid = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_midop", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                  axi_req.b_ready, axi_req.r_ready, reg_rsp.ready}), 64'(0));
        #1 rst = 1'b0;
        v = '{1'b0, 32'h5000, 32'h0, 4'h0, 0, 0, 0, 0, RESP_OKAY, 32'h55AA55AA, 1'b1, 1'b0, 32'h55AA55AA, 1'b0, 3};
        run_vec(v, "post_reset_rd");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
